// File: rtl/gray_to_binary_seq_if.sv
// Handshake bundle for gray_to_binary_seq: a Gray-code input channel and a binary result channel.
// The master modport is the producer/consumer side; the slave modport is the decoder.
interface gray_to_binary_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] bin_out;
  logic             step_err;

  modport master (
    output in_valid, gray_in, out_ready,
    input  in_ready, out_valid, bin_out, step_err
  );

  modport slave (
    input  in_valid, gray_in, out_ready,
    output in_ready, out_valid, bin_out, step_err
  );
endinterface

// File: rtl/gray_to_binary_seq.sv
// Serial Gray-to-binary decoder, one bit per clock MSB first, valid/ready on both sides.
// Define GRAY_STEP_CHECK_EN to flag accepted codes that are not a single-bit step from the previous one.
module gray_to_binary_seq #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_to_binary_seq_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] bin_q;
  logic             carry_q;    // bin[idx+1]; zero before the MSB so bin[MSB] = g[MSB]
  logic             in_ready_q;
  logic             accept;
  logic             bit_d;

  assign accept = bus.in_valid && in_ready_q;
  assign bit_d  = carry_q ^ g_q[idx_q];

  // NOTE: every output of a combinational block gets a default first; a missed path would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)              state_d = CONV;
      CONV:    if (idx_q == '0)         state_d = DONE;
      DONE:    if (bus.out_ready)       state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  // NOTE: datapath registers are reset too, so bin_out reads 0 out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      g_q     <= bus.gray_in;
      idx_q   <= IW'(WIDTH - 1);
      carry_q <= 1'b0;
    end else if (state_q == CONV) begin
      bin_q[idx_q] <= bit_d;
      carry_q      <= bit_d;
      idx_q        <= idx_q - IW'(1);
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             err_q;

  // A repeated code counts as a violation, as does any multi-bit jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      err_q       <= have_prev_q && ($countones(bus.gray_in ^ prev_q) != 1);
      prev_q      <= bus.gray_in;
      have_prev_q <= 1'b1;
    end
  end

  assign bus.step_err = (state_q == DONE) && err_q;
`else
  assign bus.step_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin_out   = bin_q;

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Self-checking bench for gray_to_binary_seq (WIDTH=4): directed table, exhaustive sweep,
// backpressure, reset mid-conversion and randomized codes against a behavioural model.
module tb_gray_to_binary_seq;

  localparam int W = 4;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gray_to_binary_seq_if #(.WIDTH(W)) bus ();

  gray_to_binary_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         err;   // expected step_err when the step check is built in
  } vec_t;

  vec_t vecs [7];

  // Model of the step checker's history.
  logic [W-1:0] m_prev;
  logic         m_have;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decode by searching for the binary value whose Gray code matches.
  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < (1 << W); b++) begin
      logic [W-1:0] bb;
      bb = W'(b);
      if ((bb ^ (bb >> 1)) == g) r = bb;
    end
    return r;
  endfunction

  function automatic int popcnt(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic logic model_step(input logic [W-1:0] g);
    logic e;
    e      = STEP_EN && m_have && (popcnt(g ^ m_prev) != 1);
    m_prev = g;
    m_have = 1'b1;
    return e;
  endfunction

  // One full transaction; bp = cycles of out_ready=0 after out_valid rises.
  task automatic send(input logic [W-1:0] g, input logic [W-1:0] eb, input logic ee,
                      input int bp, input string tag);
    int n;
    bit got;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready before accept"}, 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.gray_in   = g;
    bus.out_ready = (bp == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.gray_in  = ~g;
    check({tag, " in_ready after accept"}, 32'(bus.in_ready), 0);
    got = 1'b0;
    n   = 0;
    while (!got && n < 3 * W) begin
      @(posedge clk); #1; n++;
      if (bus.out_valid === 1'b1) got = 1'b1;
      else check({tag, " in_ready during conv"}, 32'(bus.in_ready), 0);
    end
    check({tag, " latency"}, 32'(n), W);
    check({tag, " bin_out"}, 32'(bus.bin_out), 32'(eb));
    check({tag, " step_err"}, 32'(bus.step_err), 32'(ee));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({tag, " held out_valid"}, 32'(bus.out_valid), 1);
      check({tag, " held bin_out"}, 32'(bus.bin_out), 32'(eb));
      check({tag, " held in_ready"}, 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid after xfer"}, 32'(bus.out_valid), 0);
    check({tag, " in_ready after xfer"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int  seen;
    logic [W-1:0] g;
    logic         e;

    vecs[0] = '{4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{4'b0001, 4'b0001, 1'b0};
    vecs[2] = '{4'b0011, 4'b0010, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 1'b1};
    vecs[5] = '{4'b0110, 4'b0100, 1'b1};
    vecs[6] = '{4'b1000, 4'b1111, 1'b1};

    m_prev        = '0;
    m_have        = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.gray_in   = '0;
    bus.out_ready = 1'b1;

    #3;
    check("reset in_ready", 32'(bus.in_ready), 0);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset bin_out", 32'(bus.bin_out), 0);
    check("reset step_err", 32'(bus.step_err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", 32'(bus.in_ready), 1);
    check("release out_valid", 32'(bus.out_valid), 0);
    check("release bin_out", 32'(bus.bin_out), 0);

    // Directed table, first codes after reset, step history in order.
    foreach (vecs[i]) begin
      e = model_step(vecs[i].gray);
      send(vecs[i].gray, vecs[i].bin, STEP_EN & vecs[i].err, 0, $sformatf("vec%0d", i));
    end

    // Exhaustive: every Gray code b^(b>>1) decodes to b.
    for (int b = 0; b < (1 << W); b++) begin
      logic [W-1:0] bb;
      bb = W'(b);
      g  = bb ^ (bb >> 1);
      e  = model_step(g);
      send(g, bb, e, 0, $sformatf("exh%0d", b));
    end

    // Backpressure: result held for 5 cycles.
    e = model_step(4'b0110);
    send(4'b0110, 4'b0100, e, 5, "bp");

    // Reset two cycles into a conversion drops the transaction.
    while (bus.in_ready !== 1'b1) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.gray_in  = 4'b1010;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(bus.in_ready), 0);
    check("midrst out_valid", 32'(bus.out_valid), 0);
    check("midrst bin_out", 32'(bus.bin_out), 0);
    check("midrst step_err", 32'(bus.step_err), 0);
    m_have = 1'b0;
    m_prev = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("midrst no stale result", 32'(seen), 0);
    e = model_step(4'b1010);
    send(4'b1010, ref_decode(4'b1010), e, 0, "post_rst");

    // Randomized codes and backpressure against the model.
    for (int i = 0; i < 30; i++) begin
      g = W'($urandom_range(0, (1 << W) - 1));
      e = model_step(g);
      send(g, ref_decode(g), e, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
